// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int HOLD_CNT_W = 8;

  // A one-requester mux still needs a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first requester at or above ptr, wrapping modulo N.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic          found
);

  // Scan from the farthest offset down so the nearest match is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx   = SW'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter_rr.sv
// Round-robin arbiter/sequencer sharing one W-bit channel among N requesters.
// Optional grant counter enabled by defining MUX_ARBITER_RR_STATS_EN.
module mux_arbiter_rr
  import mux_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 8,
  localparam int SW      = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
`ifdef MUX_ARBITER_RR_STATS_EN
  ,
  output logic [15:0]    grant_count
`endif
);

  state_t                state;
  logic [SW-1:0]         ptr;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic [SW-1:0]         pick_idx;
  logic                  pick_found;
  logic                  xfer;
  logic                  last_word;
  logic                  release_now;

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign busy        = (state == GRANT);
  assign out_valid   = busy && req[sel];
  assign xfer        = out_valid && out_ready;
  assign last_word   = (hold_cnt == HOLD_CNT_W'(MAX_HOLD - 1));
  assign release_now = !req[sel] || (xfer && last_word);

  always_comb begin
    ack = '0;
    if (xfer) ack[sel] = 1'b1;
  end

  always_comb begin
    out_data = '0;
    if (busy) out_data = data_in[int'(sel)*W +: W];
  end

  // Only IDLE looks at the picker, so other requesters cannot steal an active grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= GRANT;
            grant    <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            sel      <= pick_idx;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state    <= IDLE;
            grant    <= '0;
            hold_cnt <= '0;
            ptr      <= (sel == SW'(N - 1)) ? '0 : sel + SW'(1);
          end else if (xfer) begin
            hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUX_ARBITER_RR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count <= '0;
    end else if (state == IDLE && pick_found && grant_count != 16'hFFFF) begin
      grant_count <= grant_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/mux_arbiter_rr.md
# mux_arbiter_rr

Round-robin arbiter and sequencer that shares one W-bit output channel, a wide N-to-1 mux, among N requesters. It picks a requester, drives the mux select and a one-hot grant, and moves that requester's words over a valid/ready handshake. It holds the grant for up to MAX_HOLD transfers, then releases and rotates priority. It sits between producer blocks and any single-consumer sink in the mux datapath.

## Interface
- N, 4, number of requesters (2..16)
- W, 8, data width per requester
- MAX_HOLD, 8, maximum transfers per grant (1..255)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N  per-requester request; bit i is high while requester i has data
- data_in  in  N*W  flattened data; requester i occupies bits [i*W +: W]
- ack  out  N  one-cycle pulse on bit i when a word from requester i is accepted
- grant  out  N  one-hot registered grant; all zero when idle
- sel  out  $clog2(N)  binary index of the granted requester; drives the mux select
- out_data  out  W  data_in slice selected by sel; zero when idle
- out_valid  out  1  high when granted and req[sel] is high
- out_ready  in  1  sink accept
- busy  out  1  high in GRANT state

## Operation
- States: IDLE, GRANT.
- IDLE:
  - If any req bit is high, choose the first requester at or above the pointer ptr, wrapping modulo N.
  - Register grant and sel, reset hold_cnt to 0, then go to GRANT.
  - If no req bit is high, stay in IDLE.
- GRANT:
  - out_valid = req[sel]. A transfer occurs when out_valid && out_ready.
  - On a transfer, ack[sel] = 1 and hold_cnt increments.
- Release: go to IDLE on the next edge when either condition holds:
  - a transfer occurs with hold_cnt == MAX_HOLD-1;
  - req[sel] is low.
  - On release, ptr <= (sel+1) mod N.
- Requests from non-granted requesters are ignored during GRANT. Their req lines are sampled only in IDLE.
- out_ready while out_valid is low has no effect. ack is never asserted outside GRANT.
- Combinational paths: out_data and ack are combinational from the registered sel and the inputs. There is no combinational path from req to grant.
- Reset values: grant 0, sel 0, ptr 0, hold_cnt 0, state IDLE. Therefore busy 0, out_valid 0, ack 0, out_data 0.

## Timing
- Arbitration latency: req rises in IDLE cycle k; grant and busy are valid in cycle k+1. The earliest transfer is in cycle k+1.
- Back-to-back grants have one IDLE bubble cycle between them. Throughput is MAX_HOLD words per MAX_HOLD+1 cycles under full load.
- Hold limit: after the MAX_HOLD-th transfer, grant is 0 in the following cycle.
- Requester drop: if req[sel] falls in cycle j, there is no transfer in j and the block is IDLE in j+1.
- Simultaneous events:
  - Release and a new req in the same cycle: the new req is seen in the following IDLE cycle.
  - A transfer on the final word and req[sel] falling in the same cycle: one release, and the transfer counts.
- Reset mid-GRANT: all outputs clear immediately. An in-flight word is not acknowledged, and ptr returns to 0.
- Wrap-around: with ptr = N-1 and only req[0] high, requester 0 is granted.

## Configuration
- MUX_ARBITER_RR_STATS_EN
  - When defined, adds output grant_count [15:0]. It counts grants issued, saturates at 16'hFFFF, and resets to 0.
  - When undefined, the port and counter are absent and the remaining behaviour is identical.

## Structure
- Package mux_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the localparam function for the sel width ($clog2 with a minimum of 1);
  - the MAX_HOLD counter width constant of 8.
- Sub-module rr_pick: combinational rotate-priority picker. Inputs are req[N] and ptr. Outputs are idx and found. It is instantiated once in the arbiter.

## Test plan
- Reset: hold rst_n low with random req -> grant=0, out_valid=0, ack=0, out_data=0; after release, the first grant goes to the lowest requesting index.
- Single requester: N=4, req=4'b0100, out_ready=1, data_in[2]=8'hA5 -> sel=2 one cycle later, 8 acks, out_data=8'hA5, then 1 idle cycle and a regrant.
- Full-load rotation: req=4'b1111, out_ready=1 -> grant order 0,1,2,3,0 with exactly 8 transfers each and one bubble between grants.
- Backpressure and drop: requester 1 granted, out_ready low for 3 cycles -> no ack; req[1] drops -> IDLE next cycle, hold_cnt does not carry over.
- Wrap: after a grant to 3, only req[0] is high -> grant=4'b0001; with the macro defined, grant_count increments exactly once per grant.
- Async reset mid-transfer: rst_n falls while busy -> outputs clear in the same cycle; the next grant starts from ptr=0.
